// File: rtl/div_pkg.sv
// Shared types and sizing for the multicycle integer divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_ITERS = DIV_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_if.sv
// Request/response bundle between a divider client (master) and div_unit (slave).
interface div_if #(
    parameter int unsigned WIDTH = 32
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             ready;
    logic             exception;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, ready, exception
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, ready, exception
    );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration on magnitudes.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] p_next,
    output logic [WIDTH-1:0] a_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // p < d always holds, so the shifted value minus d fits WIDTH+1 signed bits.
    assign shifted = {p, a[WIDTH-1]};
    assign trial   = shifted - {1'b0, d};

    assign p_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign a_next = {a[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// Multicycle restoring divider: one iteration per clock, divide-by-zero flagged.
// Define DIV_SIGNED_EN for two's-complement signed division; unsigned otherwise.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic clock,
    input  logic reset_n,
    div_if.slave bus
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    div_state_e       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] d;
    logic             q_neg;
    logic             r_neg;

    logic [WIDTH-1:0] p_next;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic             dvd_sign;
    logic             dvs_sign;
    logic             div_zero;
    logic             last_step;

    assign div_zero  = ~|bus.divisor;
    assign last_step = (count == CW'(WIDTH - 1));

`ifdef DIV_SIGNED_EN
    assign dvd_sign = bus.dividend[WIDTH-1];
    assign dvs_sign = bus.divisor[WIDTH-1];
    // The magnitude of the most negative value is representable as unsigned.
    assign dvd_mag  = dvd_sign ? (~bus.dividend + 1'b1) : bus.dividend;
    assign dvs_mag  = dvs_sign ? (~bus.divisor + 1'b1) : bus.divisor;
`else
    assign dvd_sign = 1'b0;
    assign dvs_sign = 1'b0;
    assign dvd_mag  = bus.dividend;
    assign dvs_mag  = bus.divisor;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p      (p),
        .a      (a),
        .d      (d),
        .p_next (p_next),
        .a_next (a_next)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            count         <= '0;
            p             <= '0;
            a             <= '0;
            d             <= '0;
            q_neg         <= 1'b0;
            r_neg         <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.busy      <= 1'b0;
            bus.ready     <= 1'b0;
            bus.exception <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    bus.ready <= 1'b0;
                    if (bus.start) begin
                        if (div_zero) begin
                            state         <= DONE;
                            bus.exception <= 1'b1;
                            bus.quotient  <= '0;
                            bus.remainder <= '0;
                            bus.ready     <= 1'b1;
                        end else begin
                            state         <= RUN;
                            a             <= dvd_mag;
                            d             <= dvs_mag;
                            p             <= '0;
                            count         <= '0;
                            q_neg         <= dvd_sign ^ dvs_sign;
                            r_neg         <= dvd_sign;
                            bus.exception <= 1'b0;
                            bus.busy      <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    p     <= p_next;
                    a     <= a_next;
                    count <= count + 1'b1;
                    if (last_step) begin
                        state         <= DONE;
                        bus.quotient  <= q_neg ? (~a_next + 1'b1) : a_next;
                        bus.remainder <= r_neg ? (~p_next + 1'b1) : p_next;
                        bus.busy      <= 1'b0;
                        bus.ready     <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bus.busy  <= 1'b0;
                    bus.ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed vectors, monitor checks results and ready timing.
module tb_div_unit;
    import div_pkg::*;

    localparam int unsigned W = DIV_WIDTH;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    div_if #(.WIDTH(W)) bus ();

    div_unit #(
        .WIDTH (W)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         e;
        int           at;
        string        name;
    } exp_t;

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         e;
    } vec_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per ready pulse, flags stray or missing pulses.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (bus.ready) begin
                check("ready_busy_overlap", W'(bus.ready & bus.busy), '0);
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ready: got ready=1 expected ready=0 (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_quotient"}, bus.quotient, e.q);
                    check({e.name, "_remainder"}, bus.remainder, e.r);
                    check({e.name, "_exception"}, W'(bus.exception), W'(e.e));
                    check({e.name, "_ready_cycle"}, W'(cyc), W'(e.at));
                end
            end else if (sb.size() > 0 && cyc > sb[0].at) begin
                e = sb.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL %s_ready_missing: got no ready expected ready at cycle %0d", e.name,
                         e.at);
            end
        end
    end

    task automatic issue(input string name, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic e,
                         input bit track, output int acc);
        exp_t x;
        @(negedge clock);
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        acc          = cyc + 1;
        if (track) begin
            x.q    = q;
            x.r    = r;
            x.e    = e;
            x.at   = (dvs == '0) ? acc : acc + 32;
            x.name = name;
            sb.push_back(x);
        end
        @(negedge clock);
        bus.start    = 1'b0;
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clock);
        if (sb.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_cycle(input int target);
        for (int i = 0; i < 200 && cyc < target; i++) @(negedge clock);
    endtask

    vec_t vecs[$];

    initial begin
        int acc;
        int k;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        vecs.push_back('{dvd: 100, dvs: 7, q: 14, r: 2, e: 0});
        vecs.push_back('{dvd: 123456789, dvs: 1000, q: 123456, r: 789, e: 0});
        vecs.push_back('{dvd: 7, dvs: 9, q: 0, r: 7, e: 0});
        vecs.push_back('{dvd: 0, dvs: 5, q: 0, r: 0, e: 0});
        vecs.push_back('{dvd: 32'hFFFFFFFF, dvs: 32'hFFFFFFFF, q: 1, r: 0, e: 0});
        vecs.push_back('{dvd: 32'hFFFFFFFF, dvs: 1, q: 32'hFFFFFFFF, r: 0, e: 0});
`ifdef DIV_SIGNED_EN
        vecs.push_back('{dvd: 32'h80000000, dvs: 32'hFFFFFFFF, q: 32'h80000000, r: 0, e: 0});
        vecs.push_back('{dvd: 32'hFFFFFF9C, dvs: 7, q: 32'hFFFFFFF2, r: 32'hFFFFFFFE, e: 0});
        vecs.push_back('{dvd: 100, dvs: 32'hFFFFFFF9, q: 32'hFFFFFFF2, r: 2, e: 0});
`else
        vecs.push_back('{dvd: 32'h80000000, dvs: 32'hFFFFFFFF, q: 0, r: 32'h80000000, e: 0});
        vecs.push_back('{dvd: 32'hFFFFFF9C, dvs: 7, q: 32'h24924916, r: 2, e: 0});
        vecs.push_back('{dvd: 100, dvs: 32'hFFFFFFF9, q: 0, r: 100, e: 0});
`endif
        vecs.push_back('{dvd: 32'h00000063, dvs: 32'h0000000A, q: 9, r: 9, e: 0});

        repeat (3) @(negedge clock);
        check("reset_quotient", bus.quotient, '0);
        check("reset_remainder", bus.remainder, '0);
        check("reset_busy", W'(bus.busy), '0);
        check("reset_ready", W'(bus.ready), '0);
        check("reset_exception", W'(bus.exception), '0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        foreach (vecs[i]) begin
            issue($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r,
                  vecs[i].e, 1'b1, acc);
            drain();
        end

        // Divide by zero: one-cycle latency, busy never raised, exception held afterwards.
        issue("div0", 5, 0, 0, 0, 1'b1, 1'b1, acc);
        check("div0_busy", W'(bus.busy), '0);
        drain();
        repeat (3) @(negedge clock);
        check("div0_exception_held", W'(bus.exception), W'(1));
        check("div0_busy_after", W'(bus.busy), '0);

        // Start mid-RUN is ignored; start during DONE is accepted back to back.
        issue("mid_run_first", 9, 3, 3, 0, 1'b0, 1'b1, k);
        repeat (10) @(negedge clock);
        issue("mid_run_ignored", 50, 5, 0, 0, 1'b0, 1'b0, acc);
        wait_cycle(k + 31);
        issue("done_accept", 50, 5, 10, 0, 1'b0, 1'b1, acc);
        check("done_accept_edge", W'(acc), W'(k + 33));
        drain();
        check("hold_quotient", bus.quotient, W'(10));

        // Reset mid-RUN aborts with no ready pulse.
        issue("aborted", 7, 2, 0, 0, 1'b0, 1'b0, k);
        wait_cycle(k + 10);
        reset_n = 1'b0;
        #1;
        check("abort_quotient", bus.quotient, '0);
        check("abort_remainder", bus.remainder, '0);
        check("abort_busy", W'(bus.busy), '0);
        check("abort_ready", W'(bus.ready), '0);
        check("abort_exception", W'(bus.exception), '0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        issue("after_reset", 1, 1, 1, 0, 1'b0, 1'b1, acc);
        drain();

        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
